// File: rtl/reg_file_gen.sv
// Register file with one write port and two combinational read ports.
// Supports per-byte write enables, an optional hardwired-zero register 0 and optional write-to-read bypass.
module reg_file_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WIDTH-1:0]     rdata_b,
  output logic                 wr_err
);

  localparam int unsigned     NB        = WIDTH / 8;
  // The extra bit lets DEPTH == 2**ADDR_W be represented, so every address then counts as in range.
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_err_q, wr_err_d;

  logic             waddr_ok;
  logic             wr_zero;
  logic             wr_commit;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] mem_d;

  assign waddr_ok  = ({1'b0, waddr} < DEPTH_LIM);
  assign wr_zero   = ZERO_REG && (waddr == '0);
  assign wr_commit = wen && waddr_ok && !wr_zero;
  assign wr_err_d  = wr_err_q | (wen & ~waddr_ok);

  // Merged write word: new bytes where enabled, stored bytes elsewhere.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    wr_old = '0;
    if (waddr_ok) wr_old = mem_q[waddr];
    mem_d = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) mem_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset here on purpose. Register contents must read as zero after rst.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_err_q <= wr_err_d;
      if (wr_commit) mem_q[waddr] <= mem_d;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (({1'b0, raddr_a} < DEPTH_LIM) && !(ZERO_REG && (raddr_a == '0))) begin
      if (BYPASS && !rst && wr_commit && (raddr_a == waddr)) rdata_a = mem_d;
      else                                                   rdata_a = mem_q[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (({1'b0, raddr_b} < DEPTH_LIM) && !(ZERO_REG && (raddr_b == '0))) begin
      if (BYPASS && !rst && wr_commit && (raddr_b == waddr)) rdata_b = mem_d;
      else                                                   rdata_b = mem_q[raddr_b];
    end
  end

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_file_gen.sv
// Bench for reg_file_gen. Two configurations are driven in parallel: the default build, and a
// DEPTH=24 build with no zero register and no bypass. Both are compared against a word-array model.
module tb_reg_file_gen;

  logic        clk = 1'b0;
  logic        rst, wen;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] ra0, rb0, ra1, rb1;
  logic        err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_gen dut0 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0), .wr_err(err0)
  );

  reg_file_gen #(.DEPTH(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1), .wr_err(err1)
  );

  // Reference model: one word array per configuration, indexed by configuration.
  logic [31:0] mdl [2][32];
  logic        mdl_err [2];
  int          cfg_depth [2] = '{32, 24};
  bit          cfg_zero  [2] = '{1'b1, 1'b0};
  bit          cfg_byp   [2] = '{1'b1, 1'b0};

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input int d, input logic [4:0] addr);
    logic [31:0] w;
    if (int'(addr) >= cfg_depth[d]) return 32'h0;
    if (cfg_zero[d] && addr == 5'd0) return 32'h0;
    w = mdl[d][addr];
    if (cfg_byp[d] && wen && !rst && addr == waddr) w = merge(w, wdata, wbe);
    return w;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
        mdl_err[d] = 1'b0;
      end else if (wen) begin
        if (int'(waddr) >= cfg_depth[d]) mdl_err[d] = 1'b1;
        else if (!(cfg_zero[d] && waddr == 5'd0)) mdl[d][waddr] = merge(mdl[d][waddr], wdata, wbe);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dut0.a"}, ra0, exp_read(0, raddr_a));
    check({tag, ".dut0.b"}, rb0, exp_read(0, raddr_b));
    check({tag, ".dut1.a"}, ra1, exp_read(1, raddr_a));
    check({tag, ".dut1.b"}, rb1, exp_read(1, raddr_b));
    check({tag, ".dut0.err"}, {31'h0, err0}, {31'h0, mdl_err[0]});
    check({tag, ".dut1.err"}, {31'h0, err1}, {31'h0, mdl_err[1]});
  endtask

  // Clock edge: the model follows the DUT, then inputs may change 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_wr(input logic w, input logic [4:0] a, input logic [31:0] dat,
                          input logic [3:0] be);
    wen = w; waddr = a; wdata = dat; wbe = be;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mdl[d][i] = 32'hx;
      mdl_err[d] = 1'bx;
    end
    rst = 1'b1; drive_wr(1'b0, 5'd0, 32'h0, 4'h0); raddr_a = 5'd0; raddr_b = 5'd0;
    tick();
    rst = 1'b0;

    // Reset sweep across all addresses.
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i); #1;
      check($sformatf("reset_sweep[%0d]", i), ra0 | rb0 | ra1 | rb1, 32'h0);
    end
    check("reset_err", {30'h0, err0, err1}, 32'h0);

    // Full-word write, then hold with wen low.
    drive_wr(1'b1, 5'd5, 32'hABCDABCD, 4'hF); raddr_a = 5'd5; raddr_b = 5'd5; #1;
    check_all("wr5_pre");
    tick();
    drive_wr(1'b0, 5'd5, 32'hBABAADAD, 4'hF); #1;
    check("wr5_a", ra0, 32'hABCDABCD);
    check("wr5_b", rb1, 32'hABCDABCD);
    for (int i = 0; i < 3; i++) tick();
    check("wr5_hold", ra0 & rb0 & ra1 & rb1, 32'hABCDABCD);
    check_all("wr5_hold_all");

    // Byte-enable merge.
    drive_wr(1'b1, 5'd7, 32'h12345678, 4'hF); tick();
    drive_wr(1'b1, 5'd7, 32'hAD12BA34, 4'b0101); raddr_a = 5'd7; raddr_b = 5'd7; #1;
    check("merge_byp", ra0, 32'h12125634);
    check("merge_nobyp", rb1, 32'h12345678);
    tick();
    wen = 1'b0; #1;
    check("merge_r7_0", ra0, 32'h12125634);
    check("merge_r7_1", ra1, 32'h12125634);

    // Register 0, and bypass versus no bypass on r3.
    drive_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF); tick();
    wen = 1'b0; raddr_a = 5'd0; raddr_b = 5'd0; #1;
    check("zero_reg_on", ra0, 32'h0);
    check("zero_reg_off", ra1, 32'hFFFFFFFF);
    drive_wr(1'b1, 5'd3, 32'h11111111, 4'hF); tick();
    drive_wr(1'b1, 5'd3, 32'hDEADBEEF, 4'hF); raddr_a = 5'd3; raddr_b = 5'd3; #1;
    check("byp_on_a", ra0, 32'hDEADBEEF);
    check("byp_on_b", rb0, 32'hDEADBEEF);
    check("byp_off_a", ra1, 32'h11111111);
    check("byp_off_b", rb1, 32'h11111111);
    tick();
    wen = 1'b0; #1;
    check("byp_off_after", ra1 & rb1, 32'hDEADBEEF);

    // Out-of-range write and read on the DEPTH=24 build.
    drive_wr(1'b1, 5'd25, 32'hCAFEF00D, 4'hF); tick();
    wen = 1'b0; #1;
    check("oor_err_set", {31'h0, err1}, 32'h1);
    for (int i = 0; i < 24; i++) begin
      raddr_a = 5'(i); #1;
      check_all($sformatf("oor_nochange[%0d]", i));
    end
    for (int i = 0; i < 10; i++) tick();
    check("oor_err_sticky", {31'h0, err1}, 32'h1);
    raddr_a = 5'd30; raddr_b = 5'd25; #1;
    check("oor_read30", ra1, 32'h0);
    check("oor_read25", rb1, 32'h0);
    check("inrange_read25", rb0, 32'hCAFEF00D);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check("oor_err_clr", {31'h0, err1}, 32'h0);

    // Reset wins over a simultaneous write.
    rst = 1'b1; drive_wr(1'b1, 5'd9, 32'h5A5A5A5A, 4'hF); raddr_a = 5'd9; raddr_b = 5'd9; #1;
    check("rst_wr_nobyp", ra0, 32'h0);
    tick();
    rst = 1'b0; wen = 1'b0; #1;
    check("rst_wr_r9", ra0 | ra1, 32'h0);
    wen = 1'b1; tick();
    wen = 1'b0; #1;
    check("rst_wr_after", ra0 & ra1, 32'h5A5A5A5A);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive_wr(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
               4'($urandom_range(0, 15)));
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      check_all($sformatf("rand[%0d]", n));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
